// File: rtl/ma_stage_if.sv
// Data-memory port of the memory-access stage: request/grant handshake with
// a separate rvalid return channel.
interface ma_stage_if;
   logic        dmem_req;
   logic        dmem_we;
   logic [29:0] dmem_adr;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_wdata;
   logic        dmem_gnt;
   logic        dmem_rvalid;
   logic [31:0] dmem_rdata;

   modport master (
      output dmem_req, dmem_we, dmem_adr, dmem_be, dmem_wdata,
      input  dmem_gnt, dmem_rvalid, dmem_rdata
   );

   modport slave (
      input  dmem_req, dmem_we, dmem_adr, dmem_be, dmem_wdata,
      output dmem_gnt, dmem_rvalid, dmem_rdata
   );
endinterface

// File: rtl/ma_stage.sv
// RV32I memory-access stage: drives the data-memory port, aligns load data,
// stalls while a transaction is outstanding and owns the WB/WB2 registers.
module ma_stage (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_ld_ma,
   input  logic        cmd_st_ma,
   input  logic [4:0]  rd_adr_ma,
   input  logic [31:0] rd_data_ma,
   input  logic        wbk_rd_reg_ma,
   input  logic [31:0] st_data_ma,
   input  logic [2:0]  ldst_code_ma,
   input  logic        stall,
   input  logic        rst_pipe,
   ma_stage_if.master  dmem,
   output logic        stall_ma,
   output logic        misalign_ma,
   output logic [4:0]  rd_adr_wb,
   output logic [31:0] wbk_data_wb,
   output logic        wbk_rd_reg_wb,
   output logic [4:0]  rd_adr_wb2,
   output logic [31:0] wbk_data_wb2,
   output logic        wbk_rd_reg_wb2
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT,
      ST_DONE,
      ST_DISCARD
   } state_e;

   function automatic logic [31:0] align_load(input logic [31:0] word,
                                              input logic [1:0]  ofs,
                                              input logic [2:0]  code);
      logic signed [15:0] h;
      logic signed [7:0]  b;
      h = ofs[1] ? word[31:16] : word[15:0];
      b = ofs[0] ? h[15:8] : h[7:0];
      case (code)
         3'b000:  align_load = 32'(b);
         3'b100:  align_load = {24'b0, b};
         3'b001:  align_load = 32'(h);
         3'b101:  align_load = {16'b0, h};
         default: align_load = word;
      endcase
   endfunction

   function automatic logic [3:0] store_be(input logic [1:0] ofs,
                                           input logic [1:0] size);
      case (size)
         2'b00:   store_be = 4'b0001 << ofs;
         2'b01:   store_be = ofs[1] ? 4'b1100 : 4'b0011;
         default: store_be = 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] store_wdata(input logic [31:0] d,
                                               input logic [1:0]  size);
      case (size)
         2'b00:   store_wdata = {4{d[7:0]}};
         2'b01:   store_wdata = {2{d[15:0]}};
         default: store_wdata = d;
      endcase
   endfunction

   state_e      state_q, state_d;
   logic [31:0] hold_q;
   logic [4:0]  wb_rd_adr_q,  wb2_rd_adr_q;
   logic [31:0] wb_data_q,    wb2_data_q;
   logic        wb_we_q,      wb2_we_q;

   logic        mem_op, issue, req, done_now, capture;
   logic [31:0] aligned, wb_data_d;

   assign mem_op      = cmd_ld_ma | cmd_st_ma;
   assign misalign_ma = mem_op &
                        (((ldst_code_ma[1:0] == 2'b01) & rd_data_ma[0]) |
                         (ldst_code_ma[1] & (rd_data_ma[1:0] != 2'b00)));
   assign issue       = mem_op & ~misalign_ma;
   assign aligned     = align_load(dmem.dmem_rdata, rd_data_ma[1:0], ldst_code_ma);

   always_comb begin
      state_d  = state_q;
      req      = 1'b0;
      done_now = 1'b0;
      capture  = 1'b0;
      case (state_q)
         ST_IDLE, ST_REQ: begin
            if (issue) begin
               // A flush withdraws the request so no grant can be orphaned.
               req = ~rst_pipe;
               if (dmem.dmem_gnt & ~rst_pipe) begin
                  if (cmd_ld_ma) begin
                     state_d = ST_WAIT;
                  end else begin
                     done_now = 1'b1;
                     state_d  = stall ? ST_DONE : ST_IDLE;
                  end
               end else begin
                  state_d = ST_REQ;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (dmem.dmem_rvalid) begin
               done_now = 1'b1;
               capture  = 1'b1;
               state_d  = stall ? ST_DONE : ST_IDLE;
            end
         end
         ST_DONE: begin
            if (!stall) state_d = ST_IDLE;
         end
         ST_DISCARD: begin
            if (dmem.dmem_rvalid) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      // A flushed load still owes one rvalid unless it arrives in this very cycle.
      if (rst_pipe) begin
         capture = 1'b0;
         if ((state_q == ST_WAIT || state_q == ST_DISCARD) && !dmem.dmem_rvalid)
            state_d = ST_DISCARD;
         else
            state_d = ST_IDLE;
      end
   end

   assign stall_ma = (state_q == ST_DISCARD) |
                     (issue & ~done_now & (state_q != ST_DONE));

   assign dmem.dmem_req   = req;
   assign dmem.dmem_we    = req & ~cmd_ld_ma;
   assign dmem.dmem_adr   = rd_data_ma[31:2];
   assign dmem.dmem_be    = cmd_ld_ma ? 4'b1111 : store_be(rd_data_ma[1:0], ldst_code_ma[1:0]);
   assign dmem.dmem_wdata = store_wdata(st_data_ma, ldst_code_ma[1:0]);

   assign wb_data_d = cmd_ld_ma ? (done_now ? aligned : hold_q) : rd_data_ma;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         if (capture) hold_q <= aligned;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_rd_adr_q  <= '0;
         wb_data_q    <= '0;
         wb_we_q      <= 1'b0;
         wb2_rd_adr_q <= '0;
         wb2_data_q   <= '0;
         wb2_we_q     <= 1'b0;
      end else if (rst_pipe) begin
         wb_rd_adr_q  <= '0;
         wb_data_q    <= '0;
         wb_we_q      <= 1'b0;
         wb2_rd_adr_q <= '0;
         wb2_data_q   <= '0;
         wb2_we_q     <= 1'b0;
      end else if (!stall) begin
         wb_rd_adr_q  <= rd_adr_ma;
         wb_data_q    <= wb_data_d;
         wb_we_q      <= wbk_rd_reg_ma & ~misalign_ma;
         wb2_rd_adr_q <= wb_rd_adr_q;
         wb2_data_q   <= wb_data_q;
         wb2_we_q     <= wb_we_q;
      end
   end

   assign rd_adr_wb      = wb_rd_adr_q;
   assign wbk_data_wb    = wb_data_q;
   assign wbk_rd_reg_wb  = wb_we_q;
   assign rd_adr_wb2     = wb2_rd_adr_q;
   assign wbk_data_wb2   = wb2_data_q;
   assign wbk_rd_reg_wb2 = wb2_we_q;

endmodule

// File: tb/tb_ma_stage.sv
// Bench for ma_stage: a configurable-latency data memory plus a queue of
// expected WB entries that is popped each time the stage advances.
module tb_ma_stage;

   logic        clk;
   logic        rst_n;
   logic        cmd_ld_ma, cmd_st_ma;
   logic [4:0]  rd_adr_ma;
   logic [31:0] rd_data_ma;
   logic        wbk_rd_reg_ma;
   logic [31:0] st_data_ma;
   logic [2:0]  ldst_code_ma;
   logic        ext_stall;
   logic        rst_pipe;
   logic        stall;
   logic        stall_ma, misalign_ma;
   logic [4:0]  rd_adr_wb, rd_adr_wb2;
   logic [31:0] wbk_data_wb, wbk_data_wb2;
   logic        wbk_rd_reg_wb, wbk_rd_reg_wb2;

   ma_stage_if dif();

   assign stall = stall_ma | ext_stall;

   ma_stage dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .cmd_ld_ma      (cmd_ld_ma),
      .cmd_st_ma      (cmd_st_ma),
      .rd_adr_ma      (rd_adr_ma),
      .rd_data_ma     (rd_data_ma),
      .wbk_rd_reg_ma  (wbk_rd_reg_ma),
      .st_data_ma     (st_data_ma),
      .ldst_code_ma   (ldst_code_ma),
      .stall          (stall),
      .rst_pipe       (rst_pipe),
      .dmem           (dif.master),
      .stall_ma       (stall_ma),
      .misalign_ma    (misalign_ma),
      .rd_adr_wb      (rd_adr_wb),
      .wbk_data_wb    (wbk_data_wb),
      .wbk_rd_reg_wb  (wbk_rd_reg_wb),
      .rd_adr_wb2     (rd_adr_wb2),
      .wbk_data_wb2   (wbk_data_wb2),
      .wbk_rd_reg_wb2 (wbk_rd_reg_wb2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
      logic        we;
   } wb_t;

   wb_t         exp_q[$];
   wb_t         prev_wb;
   logic [31:0] hold_m;
   int          n_cmp, n_err;

   // memory model state
   int          gnt_delay, rv_delay, req_age, rv_cnt;
   bit          rv_pend;
   logic [31:0] rv_word;

   // values sampled just before each rising edge
   logic        s_stall_ma, s_stall, s_req, s_gnt, s_we, s_mis, s_rvalid;
   logic [29:0] s_adr;
   logic [3:0]  s_be;
   logic [31:0] s_wdata;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_align(input logic [31:0] word,
                                             input logic [1:0]  ofs,
                                             input logic [2:0]  code);
      logic [31:0] w;
      w = word >> (8 * ofs);
      case (code)
         3'b000:  return {{24{w[7]}}, w[7:0]};
         3'b100:  return {24'h0, w[7:0]};
         3'b001:  return {{16{w[15]}}, w[15:0]};
         3'b101:  return {16'h0, w[15:0]};
         default: return word;
      endcase
   endfunction

   // One clock cycle; entered and left on a falling edge.
   task automatic tick();
      #1;
      dif.dmem_gnt    = dif.dmem_req && (req_age >= gnt_delay);
      dif.dmem_rvalid = rv_pend && (rv_cnt == 0);
      dif.dmem_rdata  = dif.dmem_rvalid ? rv_word : $urandom;
      #2;
      s_stall_ma = stall_ma;
      s_stall    = stall;
      s_req      = dif.dmem_req;
      s_gnt      = dif.dmem_gnt;
      s_we       = dif.dmem_we;
      s_mis      = misalign_ma;
      s_rvalid   = dif.dmem_rvalid;
      s_adr      = dif.dmem_adr;
      s_be       = dif.dmem_be;
      s_wdata    = dif.dmem_wdata;
      @(posedge clk);
      if (s_rvalid) rv_pend = 1'b0;
      else if (rv_pend && rv_cnt > 0) rv_cnt--;
      if (s_req && s_gnt) begin
         req_age = 0;
         if (!s_we) begin
            rv_pend = 1'b1;
            rv_cnt  = rv_delay;
         end
      end else if (s_req) begin
         req_age++;
      end else begin
         req_age = 0;
      end
      @(negedge clk);
   endtask

   task automatic do_op(input string tag, input bit ld, input bit st,
                        input logic [2:0] code, input logic [4:0] rd,
                        input logic [31:0] adr, input logic [31:0] sdata,
                        input logic [31:0] word, input int gd, input int rvd,
                        input int es_start, input int es_len, input int exp_stall);
      wb_t         e, got;
      bit          mem, mis, fin;
      int          cyc, stalls, grants;
      logic [3:0]  ebe;
      logic [31:0] ewd;
      logic        wbk;

      wbk           = !st && (rd != 5'd0);
      cmd_ld_ma     = ld;
      cmd_st_ma     = st;
      ldst_code_ma  = code;
      rd_adr_ma     = rd;
      rd_data_ma    = adr;
      st_data_ma    = sdata;
      wbk_rd_reg_ma = wbk;
      gnt_delay     = gd;
      rv_delay      = rvd;
      rv_word       = word;

      mem = ld || st;
      mis = mem && (((code[1:0] == 2'b01) && adr[0]) || (code[1] && (adr[1:0] != 2'b00)));
      e.rd   = rd;
      e.we   = wbk && !mis;
      e.data = ld ? (mis ? hold_m : exp_align(word, adr[1:0], code)) : adr;
      if (ld && !mis) hold_m = e.data;
      exp_q.push_back(e);

      if (ld) begin
         ebe = 4'b1111;
         ewd = 32'h0;
      end else if (code[1:0] == 2'b00) begin
         ebe = 4'b0001 << adr[1:0];
         ewd = {4{sdata[7:0]}};
      end else if (code[1:0] == 2'b01) begin
         ebe = adr[1] ? 4'b1100 : 4'b0011;
         ewd = {2{sdata[15:0]}};
      end else begin
         ebe = 4'b1111;
         ewd = sdata;
      end

      fin = 1'b0; cyc = 0; stalls = 0; grants = 0;
      while (!fin && cyc < 60) begin
         ext_stall = (cyc >= es_start) && (cyc < es_start + es_len);
         tick();
         if (cyc == 0) chk({tag, ".misalign"}, s_mis, mis);
         if (s_stall_ma) stalls++;
         if (s_req && s_gnt) begin
            grants++;
            chk({tag, ".adr"}, s_adr, adr[31:2]);
            chk({tag, ".be"}, s_be, ebe);
            chk({tag, ".we"}, s_we, st);
            if (st) chk({tag, ".wdata"}, s_wdata, ewd);
         end
         if (!s_stall) fin = 1'b1;
         cyc++;
      end
      ext_stall = 1'b0;
      chk({tag, ".advanced"}, fin, 1);
      chk({tag, ".stall_cycles"}, stalls, exp_stall);
      chk({tag, ".grants"}, grants, (mem && !mis) ? 1 : 0);

      got = exp_q.pop_front();
      chk({tag, ".rd_wb"}, rd_adr_wb, got.rd);
      chk({tag, ".data_wb"}, wbk_data_wb, got.data);
      chk({tag, ".we_wb"}, wbk_rd_reg_wb, got.we);
      chk({tag, ".rd_wb2"}, rd_adr_wb2, prev_wb.rd);
      chk({tag, ".data_wb2"}, wbk_data_wb2, prev_wb.data);
      chk({tag, ".we_wb2"}, wbk_rd_reg_wb2, prev_wb.we);
      prev_wb = got;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_cmp = 0; n_err = 0;
      hold_m = 32'h0; prev_wb = '0;
      gnt_delay = 0; rv_delay = 0; req_age = 0; rv_cnt = 0; rv_pend = 1'b0;
      rv_word = 32'h0;
      dif.dmem_gnt = 1'b0; dif.dmem_rvalid = 1'b0; dif.dmem_rdata = 32'h0;
      cmd_ld_ma = 1'b0; cmd_st_ma = 1'b0; rd_adr_ma = 5'd0; rd_data_ma = 32'h0;
      wbk_rd_reg_ma = 1'b0; st_data_ma = 32'h0; ldst_code_ma = 3'b000;
      ext_stall = 1'b0; rst_pipe = 1'b0;
      rst_n = 1'b0;

      repeat (2) @(negedge clk);
      chk("rst.stall_ma", stall_ma, 0);
      chk("rst.req", dif.dmem_req, 0);
      chk("rst.we", dif.dmem_we, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst.rd_wb", rd_adr_wb, 0);
      chk("rst.data_wb", wbk_data_wb, 0);
      chk("rst.we_wb", wbk_rd_reg_wb, 0);
      chk("rst.data_wb2", wbk_data_wb2, 0);
      chk("rst.we_wb2", wbk_rd_reg_wb2, 0);
      chk("rst.stall_ma_run", stall_ma, 0);

      //     tag        ld st code    rd     adr           sdata         word          gd rvd es_s es_l stl
      do_op("sw",       0, 1, 3'b010, 5'd0,  32'h104,      32'hDEADBEEF, 32'h0,        0, 0,  0,   0,   0);
      do_op("sb",       0, 1, 3'b000, 5'd0,  32'h103,      32'h000000A5, 32'h0,        0, 0,  0,   0,   0);
      do_op("lb",       1, 0, 3'b000, 5'd5,  32'h102,      32'h0,        32'h12F03456, 0, 0,  0,   0,   1);
      do_op("lbu",      1, 0, 3'b100, 5'd6,  32'h102,      32'h0,        32'h12F03456, 0, 0,  0,   0,   1);
      do_op("lh_mis",   1, 0, 3'b001, 5'd7,  32'h201,      32'h0,        32'h0,        3, 0,  0,   0,   0);
      do_op("lw_gnt3",  1, 0, 3'b010, 5'd8,  32'h200,      32'h0,        32'h89ABCDEF, 3, 0,  0,   0,   4);
      do_op("lh_rv2",   1, 0, 3'b001, 5'd10, 32'h202,      32'h0,        32'h80017FFF, 0, 2,  0,   0,   3);
      do_op("lhu",      1, 0, 3'b101, 5'd11, 32'h200,      32'h0,        32'h12348765, 0, 0,  0,   0,   1);
      do_op("alu",      0, 0, 3'b000, 5'd3,  32'h00001234, 32'h0,        32'h0,        0, 0,  0,   0,   0);
      do_op("sh_done",  0, 1, 3'b001, 5'd0,  32'h106,      32'h1234ABCD, 32'h0,        0, 0,  0,   2,   0);
      do_op("lw_done",  1, 0, 3'b010, 5'd12, 32'h400,      32'h0,        32'hCAFEBABE, 0, 0,  1,   3,   1);
      do_op("sw_mis",   0, 1, 3'b010, 5'd0,  32'h101,      32'h11223344, 32'h0,        0, 0,  0,   0,   0);
      do_op("alu2",     0, 0, 3'b000, 5'd4,  32'h00000077, 32'h0,        32'h0,        0, 0,  0,   0,   0);

      // load flushed while waiting for its data; the late rvalid must be swallowed
      cmd_ld_ma = 1'b1; cmd_st_ma = 1'b0; ldst_code_ma = 3'b010; rd_adr_ma = 5'd9;
      rd_data_ma = 32'h300; wbk_rd_reg_ma = 1'b1;
      gnt_delay = 0; rv_delay = 1; rv_word = 32'h55AA55AA;
      tick();
      chk("rp.stall_gnt", s_stall_ma, 1);
      chk("rp.grant", s_req && s_gnt, 1);
      rst_pipe = 1'b1;
      tick();
      rst_pipe = 1'b0;
      chk("rp.rd_wb", rd_adr_wb, 0);
      chk("rp.data_wb", wbk_data_wb, 0);
      chk("rp.we_wb", wbk_rd_reg_wb, 0);
      chk("rp.rd_wb2", rd_adr_wb2, 0);
      chk("rp.data_wb2", wbk_data_wb2, 0);
      chk("rp.we_wb2", wbk_rd_reg_wb2, 0);
      prev_wb = '0;
      do_op("rp_sw",    0, 1, 3'b010, 5'd0,  32'h104,      32'h0BADF00D, 32'h0,        0, 0,  0,   0,   1);

      do_op("lb_neg",   1, 0, 3'b000, 5'd13, 32'h101,      32'h0,        32'h0000C300, 0, 0,  0,   0,   1);
      do_op("l011_w",   1, 0, 3'b011, 5'd14, 32'h500,      32'h0,        32'h13579BDF, 0, 1,  0,   0,   2);
      do_op("lh_mis2",  1, 0, 3'b101, 5'd15, 32'h203,      32'h0,        32'h0,        0, 0,  0,   0,   0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
